// File: rtl/load_read_arbiter.sv
// load_read_arbiter: round-robin share of one DRAM read path between two load engines.
// Define LOAD_ARB_FIXED_PRIO_EN to make req0 always win a tie.
module load_read_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH = 32
) (
  input  logic                          kernel_clk,
  input  logic                          kernel_rst,
  input  logic                          req0_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] req0_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  req0_size,
  output logic                          req0_done,
  output logic                          req0_tvalid,
  input  logic                          req0_tready,
  output logic                          req0_tlast,
  output logic [C_M_AXI_DATA_WIDTH-1:0] req0_tdata,
  input  logic                          req1_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] req1_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  req1_size,
  output logic                          req1_done,
  output logic                          req1_tvalid,
  input  logic                          req1_tready,
  output logic                          req1_tlast,
  output logic [C_M_AXI_DATA_WIDTH-1:0] req1_tdata,
  output logic                          read_start,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] dram_xfer_start_addr,
  output logic [C_XFER_SIZE_WIDTH-1:0]  dram_xfer_size_in_bytes,
  input  logic                          read_done,
  input  logic                          data_tvalid,
  output logic                          data_tready,
  input  logic                          data_tlast,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata,
  output logic                          grant,
  output logic                          busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;
  state_t state_q, state_d;
  logic pend0_q, pend0_d, pend1_q, pend1_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d, xaddr_q, xaddr_d;
  logic [C_XFER_SIZE_WIDTH-1:0] size0_q, size0_d, size1_q, size1_d, xsize_q, xsize_d;
  logic grant_q, grant_d, last_q, last_d, rd_seen_q, rd_seen_d, last_seen_q, last_seen_d;
  logic acc0, acc1, sel, xfer, fin;
  assign xfer = state_q == XFER;
  assign fin = state_q == DONE;
  assign acc0 = req0_start & ~pend0_q;
  assign acc1 = req1_start & ~pend1_q;
`ifdef LOAD_ARB_FIXED_PRIO_EN
  assign sel = ~pend0_q;
`else
  assign sel = (pend0_q & pend1_q) ? ~last_q : pend1_q;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    xaddr_d = xaddr_q;
    xsize_d = xsize_q;
    rd_seen_d = rd_seen_q;
    last_seen_d = last_seen_q;
    case (state_q)
      IDLE: if (pend0_q | pend1_q) begin
        grant_d = sel;
        if ((sel ? size1_q : size0_q) == '0) state_d = DONE;
        else begin
          state_d = ISSUE;
          xaddr_d = sel ? addr1_q : addr0_q;
          xsize_d = sel ? size1_q : size0_q;
        end
      end
      ISSUE: begin
        state_d = XFER;
        rd_seen_d = 1'b0;
        last_seen_d = 1'b0;
      end
      XFER: begin
        rd_seen_d = rd_seen_q | read_done;
        last_seen_d = last_seen_q | (data_tvalid & data_tready & data_tlast);
        state_d = (rd_seen_d & last_seen_d) ? DONE : XFER;
      end
      DONE: begin
        state_d = IDLE;
        last_d = grant_q;
      end
    endcase
    // a start from the owner during DONE is dropped because pending is still set
    pend0_d = acc0 | (pend0_q & ~(fin & ~grant_q));
    pend1_d = acc1 | (pend1_q & ~(fin & grant_q));
    addr0_d = acc0 ? req0_addr : addr0_q;
    size0_d = acc0 ? req0_size : size0_q;
    addr1_d = acc1 ? req1_addr : addr1_q;
    size1_d = acc1 ? req1_size : size1_q;
  end
  always_ff @(posedge kernel_clk or posedge kernel_rst) begin
    if (kernel_rst) begin
      state_q <= IDLE;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      addr0_q <= '0;
      size0_q <= '0;
      addr1_q <= '0;
      size1_q <= '0;
      xaddr_q <= '0;
      xsize_q <= '0;
      grant_q <= 1'b0;
      last_q <= 1'b1;
      rd_seen_q <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend0_q <= pend0_d;
      pend1_q <= pend1_d;
      addr0_q <= addr0_d;
      size0_q <= size0_d;
      addr1_q <= addr1_d;
      size1_q <= size1_d;
      xaddr_q <= xaddr_d;
      xsize_q <= xsize_d;
      grant_q <= grant_d;
      last_q <= last_d;
      rd_seen_q <= rd_seen_d;
      last_seen_q <= last_seen_d;
    end
  end
  assign read_start = state_q == ISSUE;
  assign dram_xfer_start_addr = xaddr_q;
  assign dram_xfer_size_in_bytes = xsize_q;
  assign data_tready = xfer & (grant_q ? req1_tready : req0_tready);
  assign req0_tvalid = xfer & ~grant_q & data_tvalid;
  assign req1_tvalid = xfer & grant_q & data_tvalid;
  assign req0_tlast = xfer & ~grant_q & data_tlast;
  assign req1_tlast = xfer & grant_q & data_tlast;
  assign req0_tdata = data_tdata;
  assign req1_tdata = data_tdata;
  assign req0_done = fin & ~grant_q;
  assign req1_done = fin & grant_q;
  assign grant = grant_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_load_read_arbiter.sv
// tb_load_read_arbiter: directed steps with beat and issue scoreboards for load_read_arbiter.
module tb_load_read_arbiter;
  logic kernel_clk = 1'b0, kernel_rst = 1'b1;
  logic req0_start = 0, req1_start = 0, req0_tready = 0, req1_tready = 0;
  logic [63:0] req0_addr = 0, req1_addr = 0, dram_xfer_start_addr;
  logic [31:0] req0_size = 0, req1_size = 0, dram_xfer_size_in_bytes;
  logic req0_done, req1_done, req0_tvalid, req1_tvalid, req0_tlast, req1_tlast;
  logic [511:0] req0_tdata, req1_tdata, data_tdata = 0;
  logic read_start, read_done = 0, data_tvalid = 0, data_tready, data_tlast = 0, grant, busy;
  int checks = 0, failures = 0;
  logic [575:0] q0[$], q1[$], qi[$];

  load_read_arbiter dut (
    .kernel_clk(kernel_clk), .kernel_rst(kernel_rst),
    .req0_start(req0_start), .req0_addr(req0_addr), .req0_size(req0_size), .req0_done(req0_done),
    .req0_tvalid(req0_tvalid), .req0_tready(req0_tready), .req0_tlast(req0_tlast), .req0_tdata(req0_tdata),
    .req1_start(req1_start), .req1_addr(req1_addr), .req1_size(req1_size), .req1_done(req1_done),
    .req1_tvalid(req1_tvalid), .req1_tready(req1_tready), .req1_tlast(req1_tlast), .req1_tdata(req1_tdata),
    .read_start(read_start), .dram_xfer_start_addr(dram_xfer_start_addr),
    .dram_xfer_size_in_bytes(dram_xfer_size_in_bytes), .read_done(read_done),
    .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tlast(data_tlast), .data_tdata(data_tdata),
    .grant(grant), .busy(busy)
  );

  always #5 kernel_clk = ~kernel_clk;

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge kernel_clk);
    #2;
  endtask

  function automatic logic [511:0] rnd();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic post(input int n, input logic [63:0] a, input logic [31:0] s);
    if (n == 0) begin req0_start = 1; req0_addr = a; req0_size = s; end
    else begin req1_start = 1; req1_addr = a; req1_size = s; end
    cyc();
    req0_start = 0;
    req1_start = 0;
  endtask

  task automatic push_issue(input logic [63:0] a, input logic [31:0] s);
    qi.push_back({480'b0, a, s});
  endtask

  // entered in the ISSUE cycle; leaves in the DONE cycle after checking the done pulse
  task automatic xfer(input int g, input int n, input bit tog, input int rd_at);
    int i = 0;
    int cnt = 0;
    bit tr;
    cyc();
    while (i < n && cnt < 64) begin
      tr = tog ? !cnt[0] : 1'b1;
      data_tvalid = 1;
      data_tdata = rnd();
      data_tlast = (i == n - 1);
      if (g == 0) begin req0_tready = tr; req1_tready = !tr; end
      else begin req1_tready = tr; req0_tready = !tr; end
      read_done = (rd_at == 0) ? (i == n - 1 && tr) : (i == n - 1 - rd_at);
      #1;
      chk("xfer_tready_mirror", data_tready, tr);
      chk("xfer_owner_tvalid", g ? req1_tvalid : req0_tvalid, 1'b1);
      chk("xfer_owner_tlast", g ? req1_tlast : req0_tlast, data_tlast);
      chk("xfer_other_tvalid", g ? req0_tvalid : req1_tvalid, 1'b0);
      chk("xfer_no_early_done", g ? req1_done : req0_done, 1'b0);
      if (tr) begin
        if (g == 0) q0.push_back({63'b0, data_tlast, data_tdata});
        else q1.push_back({63'b0, data_tlast, data_tdata});
        i++;
      end
      cnt++;
      cyc();
    end
    data_tvalid = 0;
    data_tlast = 0;
    read_done = 0;
    chk("xfer_beats_within_budget", i, n);
    #1;
    chk("done_owner", g ? req1_done : req0_done, 1'b1);
    chk("done_other", g ? req0_done : req1_done, 1'b0);
    chk("done_grant", grant, g[0]);
    chk("done_busy", busy, 1'b1);
    chk("done_tready", data_tready, 1'b0);
  endtask

  always @(negedge kernel_clk) begin
    if (req0_tvalid && req0_tready) begin
      chk("beat0_queued", q0.size() != 0, 1'b1);
      if (q0.size() != 0) chk("beat0", {63'b0, req0_tlast, req0_tdata}, q0.pop_front());
    end
    if (req1_tvalid && req1_tready) begin
      chk("beat1_queued", q1.size() != 0, 1'b1);
      if (q1.size() != 0) chk("beat1", {63'b0, req1_tlast, req1_tdata}, q1.pop_front());
    end
    if (read_start) begin
      chk("issue_queued", qi.size() != 0, 1'b1);
      if (qi.size() != 0) chk("issue_addr_size", {480'b0, dram_xfer_start_addr, dram_xfer_size_in_bytes}, qi.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    req0_tready = 1;
    data_tvalid = 1;
    data_tlast = 1;
    cyc();
    #1;
    chk("rst_read_start", read_start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 1'b0);
    chk("rst_tready", data_tready, 1'b0);
    chk("rst_tvalid0", req0_tvalid, 1'b0);
    chk("rst_tlast0", req0_tlast, 1'b0);
    chk("rst_done", {req0_done, req1_done}, 2'b00);
    chk("rst_dram", {dram_xfer_start_addr, dram_xfer_size_in_bytes}, 96'b0);
    data_tvalid = 0;
    data_tlast = 0;
    cyc();
    kernel_rst = 0;
    cyc();
    // simultaneous: req0 wins the first tie after reset, req1 follows 4 cycles later
    push_issue(64'h100, 32'd64);
    push_issue(64'h200, 32'd1024);
    req0_start = 1; req0_addr = 64'h100; req0_size = 64;
    req1_start = 1; req1_addr = 64'h200; req1_size = 1024;
    cyc();
    req0_start = 0;
    req1_start = 0;
    chk("sim_not_yet_issued", read_start, 1'b0);
    cyc();
    chk("sim_issue0", read_start, 1'b1);
    chk("sim_grant0", grant, 1'b0);
    xfer(0, 1, 0, 0);
    cyc();
    chk("sim_idle_gap", busy, 1'b0);
    cyc();
    chk("sim_issue1", read_start, 1'b1);
    chk("sim_grant1", grant, 1'b1);
    xfer(1, 16, 0, 0);
    cyc();
    // round-robin with immediate reposts
    push_issue(64'h1000, 32'd64);
    push_issue(64'h2000, 32'd64);
    req0_start = 1; req0_addr = 64'h1000; req0_size = 64;
    req1_start = 1; req1_addr = 64'h2000; req1_size = 64;
    cyc();
    req0_start = 0;
    req1_start = 0;
    cyc();
    for (int r = 0; r < 4; r++) begin
      chk("rr_issue", read_start, 1'b1);
      chk("rr_grant", grant, r[0]);
      xfer(r % 2, 1, 0, 0);
      cyc();
      if (r < 2) begin
        push_issue(64'h1100 + 64'(r), 32'd64);
        if (r % 2 == 0) begin req0_start = 1; req0_addr = 64'h1100 + 64'(r); req0_size = 64; end
        else begin req1_start = 1; req1_addr = 64'h1100 + 64'(r); req1_size = 64; end
      end
      cyc();
      req0_start = 0;
      req1_start = 0;
    end
    chk("rr_drained", busy, 1'b0);
    // single request
    push_issue(64'h1000, 32'd128);
    post(0, 64'h1000, 128);
    cyc();
    chk("single_issue", read_start, 1'b1);
    xfer(0, 2, 0, 0);
    cyc();
    chk("single_idle", busy, 1'b0);
    chk("single_done_cleared", req0_done, 1'b0);
    // backpressure: ready toggles every cycle
    push_issue(64'h4000, 32'd512);
    post(0, 64'h4000, 512);
    cyc();
    xfer(0, 8, 1, 0);
    cyc();
    // read_done 3 cycles before the last beat
    push_issue(64'h5000, 32'd512);
    post(1, 64'h5000, 512);
    cyc();
    xfer(1, 8, 0, 3);
    cyc();
    // size 0: done at k+2, no issue, held issue outputs untouched
    post(0, 64'h7000, 0);
    cyc();
    chk("zero_no_issue", read_start, 1'b0);
    chk("zero_done", req0_done, 1'b1);
    chk("zero_busy", busy, 1'b1);
    chk("zero_dram_held", {dram_xfer_start_addr, dram_xfer_size_in_bytes}, {64'h5000, 32'd512});
    cyc();
    chk("zero_done_once", req0_done, 1'b0);
    chk("zero_idle", busy, 1'b0);
    // tie with req0 served last
`ifdef LOAD_ARB_FIXED_PRIO_EN
    first = 0;
`else
    first = 1;
`endif
    if (first == 0) begin push_issue(64'h8000, 32'd64); push_issue(64'h9000, 32'd64); end
    else begin push_issue(64'h9000, 32'd64); push_issue(64'h8000, 32'd64); end
    req0_start = 1; req0_addr = 64'h8000; req0_size = 64;
    req1_start = 1; req1_addr = 64'h9000; req1_size = 64;
    cyc();
    req0_start = 0;
    req1_start = 0;
    cyc();
    chk("tie_grant_first", grant, first[0]);
    xfer(first, 1, 0, 0);
    cyc();
    cyc();
    chk("tie_grant_second", grant, !first[0]);
    xfer(1 - first, 1, 0, 0);
    cyc();
    // duplicate start while pending is ignored
    push_issue(64'h2000, 32'd64);
    post(1, 64'h2000, 64);
    post(1, 64'h9990, 128);
    chk("dup_issue", read_start, 1'b1);
    xfer(1, 1, 0, 0);
    cyc();
    cyc();
    chk("dup_not_pending", busy, 1'b0);
    // reset mid-transfer discards everything
    push_issue(64'h3000, 32'd256);
    post(0, 64'h3000, 256);
    req1_start = 1; req1_addr = 64'h6000; req1_size = 64;
    cyc();
    req1_start = 0;
    cyc();
    data_tvalid = 1;
    data_tlast = 1;
    req0_tready = 1;
    #1;
    chk("mid_tvalid0", req0_tvalid, 1'b1);
    kernel_rst = 1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_grant", grant, 1'b0);
    chk("mid_rst_tready", data_tready, 1'b0);
    chk("mid_rst_stream", {req0_tvalid, req0_tlast, req1_tvalid, req1_tlast}, 4'b0);
    chk("mid_rst_dram", {dram_xfer_start_addr, dram_xfer_size_in_bytes}, 96'b0);
    cyc();
    cyc();
    data_tvalid = 0;
    data_tlast = 0;
    kernel_rst = 0;
    cyc();
    chk("post_rst_idle", busy, 1'b0);
    cyc();
    chk("post_rst_pending_dropped", busy, 1'b0);
    push_issue(64'h4000, 32'd64);
    post(1, 64'h4000, 64);
    cyc();
    chk("fresh_issue", read_start, 1'b1);
    chk("fresh_grant", grant, 1'b1);
    xfer(1, 1, 0, 0);
    cyc();
    cyc();
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("qi_empty", qi.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_read_arbiter.md
# load_read_arbiter

Two-requester arbiter that shares the single DRAM read path (AXI read master plus its data stream) between two load engines, e.g. the feature loader and the weight loader of the GNN kernel. Each requester posts one transfer (address and byte count) with a start pulse. The arbiter grants one transfer at a time, issues it to the read master, steers the returned 512-bit stream to the owner, and pulses that owner's done when the transfer has fully drained.

## Interface
- C_M_AXI_ADDR_WIDTH, 64, DRAM byte-address width
- C_M_AXI_DATA_WIDTH, 512, stream beat width
- C_XFER_SIZE_WIDTH, 32, transfer size width (bytes)

Ports:
- kernel_clk  in  1  clock; all logic on its rising edge
- kernel_rst  in  1  reset; asynchronous, active-high
- reqN_start  in  1  (N=0,1) one-cycle transfer request
- reqN_addr  in  C_M_AXI_ADDR_WIDTH  start byte address, sampled with reqN_start
- reqN_size  in  C_XFER_SIZE_WIDTH  size in bytes, sampled with reqN_start
- reqN_done  out  1  one-cycle completion pulse
- reqN_tvalid  out  1  stream valid toward requester N
- reqN_tready  in  1  requester N ready
- reqN_tlast  out  1  last beat toward requester N
- reqN_tdata  out  C_M_AXI_DATA_WIDTH  beat data, broadcast to both requesters
- read_start  out  1  one-cycle issue pulse to the read master
- dram_xfer_start_addr  out  C_M_AXI_ADDR_WIDTH  issued address, held from ISSUE until the next issue
- dram_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  issued size, held from ISSUE until the next issue
- read_done  in  1  one-cycle pulse from the read master: all AXI bursts complete
- data_tvalid / data_tready / data_tlast / data_tdata  in/out/in/in  1/1/1/C_M_AXI_DATA_WIDTH  stream from the read master
- grant  out  1  current or last owner index
- busy  out  1  high in any state other than IDLE

## Operation
- Per requester there is a pending flag plus latched addr/size.
  - reqN_start with pending N clear: latch addr/size and set pending N.
  - reqN_start while pending N is set, including while N's own transfer is in flight: ignored. A requester waits for reqN_done before posting again.
- The state machine has four states: IDLE, ISSUE, XFER, DONE.
  - IDLE: if no request is pending, stay. Otherwise select the owner, set grant, and go to ISSUE. If the owner's size is 0, go straight to DONE instead.
  - Owner selection is round-robin. When both are pending, the requester not served last wins. After reset, req0 wins a tie.
  - ISSUE: read_start=1 for exactly this cycle, with addr/size driven from the owner's latch. Next state is XFER; clear the rd_seen and last_seen flags.
  - XFER: the stream is steered to the owner.
    - reqG_tvalid=data_tvalid, reqG_tlast=data_tlast, data_tready=reqG_tready.
    - The other requester sees tvalid=0 and tlast=0.
    - read_done sets rd_seen. A handshake (data_tvalid & data_tready & data_tlast) sets last_seen.
    - When both flags are set, counting events in the current cycle, go to DONE.
  - DONE: reqG_done=1 for one cycle, clear pending G, record last-served=G, return to IDLE.
- Outside XFER: data_tready=0 and both reqN_tvalid=0.
- A start arriving in the same cycle as the owner's done is not required to be accepted, because pending is still set; the requester reposts after done.
- A start from the non-owner is accepted at any time.

## Timing
- Reset values:
  - read_start=0, reqN_done=0, reqN_tvalid=0, reqN_tlast=0.
  - data_tready=0, busy=0, grant=0.
  - dram_xfer_start_addr=0, dram_xfer_size_in_bytes=0.
  - Both pending flags cleared; last-served=1, so req0 is preferred.
- Request to issue latency, with the arbiter idle:
  - reqN_start sampled at edge k.
  - Edge k+1: IDLE to ISSUE.
  - read_start is high from edge k+1 to edge k+2.
- Stream steering is combinational in XFER, adding zero cycles. tdata is a pure pass-through.
- Last handshake and read_done in the same cycle: done pulses 2 cycles later (XFER to DONE, then DONE to IDLE).
- Minimum spacing between two consecutive issues is 4 cycles: ISSUE, XFER (at least 1 cycle), DONE, IDLE.
- Size-0 request: done pulses at edge k+2 (IDLE to DONE to IDLE). No read_start is issued.
- kernel_rst asserted mid-transfer: everything returns to reset values immediately. Pending requests are discarded. Beats still arriving see data_tready=0. The read master is expected to be reset by the same signal.

## Configuration
- LOAD_ARB_FIXED_PRIO_EN
  - Defined: req0 always wins when both requesters are pending. Last-served is ignored.
  - Undefined (default): round-robin as specified in Operation.

## Test plan
- Single request: req0 with addr=0x1000, size=128 → read_start one cycle at edge k+1 with addr 0x1000 and size 128. The two beats are forwarded only to req0. read_done plus the tlast handshake → req0_done one pulse. req1_tvalid stays 0 throughout.
- Simultaneous requests: req0 and req1 start in the same cycle, sizes 64 and 1024 → req0 is served first, then req1 (16 beats). With LOAD_ARB_FIXED_PRIO_EN, a req0 reposted during req1's transfer does not preempt it and is served next.
- Round-robin: both requesters repost immediately after each done, over 4 rounds → grant sequence 0,1,0,1.
- Backpressure and ordering:
  - req0_tready toggles every cycle during 8 beats → data_tready mirrors it and no beat is lost or duplicated.
  - read_done arrives 3 cycles before tlast → done waits for tlast.
- Corner cases:
  - size=0 → done at edge k+2 with no read_start.
  - A duplicate start while pending → ignored; the original addr is issued.
  - kernel_rst asserted mid-XFER → all outputs return to reset values, and a fresh request afterwards works.
